// File: rtl/sm_result_display.sv
// sm_result_display
// Takes the sign-magnitude adder result, converts the magnitude to two BCD
// digits by repeated subtraction of ten, and scans the result onto a
// 4-digit active-low seven-segment display as: blank, sign, tens, ones.
// Digit 3 (leftmost) is always dark; digit 0 is the ones digit.

module sm_result_display #(
    parameter int DATA_WIDTH  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sum_valid,
    input  logic [DATA_WIDTH:0] sum,
    output logic                busy,
    output logic                done,
    output logic [3:0]          an,
    output logic [6:0]          seg,
    output logic                dp
);

    // The remainder register is at least 4 bits wide so the ones digit can
    // always be sliced from it, even for the narrowest operand width.
    localparam int REM_W = (DATA_WIDTH < 4) ? 4 : DATA_WIDTH;
    localparam int CNT_W = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);

    localparam logic [REM_W-1:0] REM_TEN   = REM_W'(10);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    // Conversion state
    state_t             state_reg;
    logic [REM_W-1:0]   rem_reg;
    logic [3:0]         tens_acc_reg;
    logic               sign_cap_reg;
    logic               nonzero_cap_reg;
    logic               busy_reg;
    logic               done_reg;

    // Values currently on the display
    logic [3:0]         ones_reg;
    logic [3:0]         tens_reg;
    logic               sign_disp_reg;

    // Scan state and registered display drive
    logic [CNT_W-1:0]   refresh_cnt_reg;
    logic [1:0]         digit_idx_reg;
    logic [3:0]         an_reg;
    logic [3:0]         an_next;
    logic [6:0]         seg_reg;
    logic [6:0]         seg_next;

    logic [DATA_WIDTH-1:0] mag;

    assign mag = sum[DATA_WIDTH-1:0];

    // BCD digit to active-low gfedcba pattern; anything above 9 is dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // Capture, repeated-subtraction conversion, and atomic display update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            rem_reg         <= '0;
            tens_acc_reg    <= '0;
            sign_cap_reg    <= 1'b0;
            nonzero_cap_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            ones_reg        <= '0;
            tens_reg        <= '0;
            sign_disp_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (sum_valid) begin
                        sign_cap_reg    <= sum[DATA_WIDTH];
                        nonzero_cap_reg <= |mag;
                        rem_reg         <= REM_W'(mag);
                        tens_acc_reg    <= '0;
                        busy_reg        <= 1'b1;
                        state_reg       <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (rem_reg >= REM_TEN) begin
                        rem_reg      <= rem_reg - REM_TEN;
                        tens_acc_reg <= tens_acc_reg + 4'd1;
                    end else begin
                        // done is high for exactly the cycle spent in DONE
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    ones_reg      <= rem_reg[3:0];
                    tens_reg      <= tens_acc_reg;
                    // negative zero is shown without a minus sign
                    sign_disp_reg <= sign_cap_reg & nonzero_cap_reg;
                    done_reg      <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Free-running refresh divider; each wrap moves the scan to the next digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_reg <= '0;
            digit_idx_reg   <= '0;
        end else if (refresh_cnt_reg == CNT_LAST) begin
            refresh_cnt_reg <= '0;
            digit_idx_reg   <= digit_idx_reg + 2'd1;
        end else begin
            refresh_cnt_reg <= refresh_cnt_reg + CNT_W'(1);
        end
    end

    // Anode select: digits 0..2 pull their own anode low, digit 3 never lights.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_anode
            if (gi < 3) begin : g_lit
                assign an_next[gi] = (digit_idx_reg != 2'(gi));
            end else begin : g_dark
                assign an_next[gi] = 1'b1;
            end
        end
    endgenerate

    // Segment content for the digit being scanned, with leading-zero blanking.
    always_comb begin
        seg_next = SEG_BLANK;
        case (digit_idx_reg)
            2'd0: seg_next = seg_decode(ones_reg);
            2'd1: begin
                if (tens_reg != 4'd0) begin
                    seg_next = seg_decode(tens_reg);
                end
            end
            2'd2: begin
                if (sign_disp_reg) begin
                    seg_next = SEG_MINUS;
                end
            end
            default: seg_next = SEG_BLANK;
        endcase
    end

    // Register the display drive so the pins never glitch on index changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_reg  <= 4'b1111;
            seg_reg <= SEG_BLANK;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign an   = an_reg;
    assign seg  = seg_reg;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_sm_result_display.sv
// Bench for sm_result_display (DATA_WIDTH=4, REFRESH_DIV=4).
// A cycle-level reference model derived from the display rules (divide and
// modulo by ten, scan index from the cycle count) checks every output each
// cycle; table vectors and hand sequences add targeted checks on top.

module tb_sm_result_display;

    localparam int DW  = 4;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          sum_valid;
    logic [DW:0]   sum;
    logic          busy;
    logic          done;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;

    int errors = 0;
    int checks = 0;

    sm_result_display #(.DATA_WIDTH(DW), .REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .sum_valid (sum_valid),
        .sum       (sum),
        .busy      (busy),
        .done      (done),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_cyc;
    bit         m_pend;
    int         m_acc_edge;
    int         m_done_cyc;
    int         m_next_ok;
    int         p_tens, p_ones;
    bit         p_sign;
    int         d_tens, d_ones;
    bit         d_sign;
    logic       exp_busy, exp_done;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Advance the model across one rising edge with the inputs seen there.
    task automatic step_model(input logic r, input logic v, input logic [DW:0] s);
        int idx;
        int mag;
        if (r) begin
            m_cyc = 0; m_pend = 0; m_next_ok = 1;
            d_tens = 0; d_ones = 0; d_sign = 0;
            exp_an = 4'b1111; exp_seg = 7'b1111111;
            exp_busy = 0; exp_done = 0;
            return;
        end
        m_cyc++;
        // display drive reflects scan index and shown value of the previous cycle
        idx = ((m_cyc - 1) / DIV) % 4;
        case (idx)
            0: begin exp_an = 4'b1110; exp_seg = digit_seg(d_ones); end
            1: begin exp_an = 4'b1101; exp_seg = (d_tens == 0) ? 7'b1111111 : digit_seg(d_tens); end
            2: begin exp_an = 4'b1011; exp_seg = d_sign ? 7'b0111111 : 7'b1111111; end
            default: begin exp_an = 4'b1111; exp_seg = 7'b1111111; end
        endcase
        if (m_pend && m_cyc == m_done_cyc + 1) begin
            d_tens = p_tens; d_ones = p_ones; d_sign = p_sign;
            m_pend = 0;
        end
        if (v && m_cyc >= m_next_ok) begin
            mag        = int'(s[DW-1:0]);
            m_pend     = 1;
            m_acc_edge = m_cyc;
            m_done_cyc = m_cyc + mag / 10 + 1;
            m_next_ok  = m_done_cyc + 2;
            p_tens     = mag / 10;
            p_ones     = mag % 10;
            p_sign     = s[DW] && (mag != 0);
        end
        exp_busy = m_pend && m_cyc >= m_acc_edge && m_cyc <= m_done_cyc;
        exp_done = m_pend && m_cyc == m_done_cyc;
    endtask

    task automatic tick();
        logic r, v;
        logic [DW:0] s;
        r = reset; v = sum_valid; s = sum;
        @(posedge clk);
        step_model(r, v, s);
        #1;
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("an",   32'(an),   32'(exp_an));
        chk("seg",  32'(seg),  32'(exp_seg));
        chk("dp",   32'(dp),   32'd1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       sign;
        logic [3:0] mag;
        int         lat;
        logic [6:0] s_ones;
        logic [6:0] s_tens;
        logic [6:0] s_sign;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat;
        int n_done;
        logic [6:0] cap0, cap1, cap2;
        bit saw3;
        logic [3:0] an_exp_seq;

        vecs[0] = '{1'b0, 4'd14, 3, 7'b0011001, 7'b1111001, 7'b1111111};
        vecs[1] = '{1'b1, 4'd7,  2, 7'b1111000, 7'b1111111, 7'b0111111};
        vecs[2] = '{1'b1, 4'd0,  2, 7'b1000000, 7'b1111111, 7'b1111111};
        vecs[3] = '{1'b0, 4'd9,  2, 7'b0010000, 7'b1111111, 7'b1111111};
        vecs[4] = '{1'b0, 4'd10, 3, 7'b1000000, 7'b1111001, 7'b1111111};
        vecs[5] = '{1'b1, 4'd15, 3, 7'b0010010, 7'b1111001, 7'b0111111};
        vecs[6] = '{1'b1, 4'd3,  2, 7'b0110000, 7'b1111111, 7'b0111111};

        reset = 1'b1; sum_valid = 1'b0; sum = '0;
        #1;
        tick(); tick();
        reset = 1'b0;
        // cycle 0 after release still shows reset values
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);

        // scan pattern after reset: each digit held for DIV cycles
        for (int c = 1; c <= 16; c++) begin
            tick();
            case ((c - 1) / 4)
                0: an_exp_seq = 4'b1110;
                1: an_exp_seq = 4'b1101;
                2: an_exp_seq = 4'b1011;
                default: an_exp_seq = 4'b1111;
            endcase
            chk("scan_an", 32'(an), 32'(an_exp_seq));
            if (an == 4'b1110) chk("scan_zero", 32'(seg), 32'h40);
        end
        $display("reset scan: 16 cycles checked");

        // table-driven single conversions
        foreach (vecs[i]) begin
            for (int k = 0; k < 3; k++) tick();
            sum = {vecs[i].sign, vecs[i].mag};
            sum_valid = 1'b1;
            tick();
            sum_valid = 1'b0;
            chk("busy_after_accept", 32'(busy), 32'd1);
            lat = 1;
            while (done !== 1'b1 && lat < 10) begin
                tick();
                lat++;
            end
            chk("latency", 32'(lat), 32'(vecs[i].lat));
            tick(); tick();
            cap0 = 'x; cap1 = 'x; cap2 = 'x; saw3 = 0;
            for (int k = 0; k < 16; k++) begin
                tick();
                if (an == 4'b1110) cap0 = seg;
                if (an == 4'b1101) cap1 = seg;
                if (an == 4'b1011) cap2 = seg;
                if (an == 4'b1111) saw3 = 1;
            end
            chk("ones_seg", 32'(cap0), 32'(vecs[i].s_ones));
            chk("tens_seg", 32'(cap1), 32'(vecs[i].s_tens));
            chk("sign_seg", 32'(cap2), 32'(vecs[i].s_sign));
            chk("digit3_dark", 32'(saw3), 32'd1);
            $display("vector %0d: sign=%0d mag=%0d latency=%0d", i, vecs[i].sign, vecs[i].mag, lat);
        end

        // sum_valid held high with alternating +14 / -3
        n_done = 0;
        sum_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            sum = (k % 2 == 0) ? 5'b0_1110 : 5'b1_0011;
            tick();
            if (done) n_done++;
        end
        sum_valid = 1'b0;
        // each conversion takes 4 or 3 edges including the idle edge: at least 8 pulses
        chk("held_valid_done_count_min", 32'(n_done >= 8), 32'd1);
        $display("held sum_valid: %0d done pulses", n_done);

        // reset in the middle of converting +14
        for (int k = 0; k < 3; k++) tick();
        sum = 5'b0_1110; sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) n_done++;
            if (an == 4'b1110) chk("abort_ones_zero", 32'(seg), 32'h40);
            if (an == 4'b1101) chk("abort_tens_blank", 32'(seg), 32'h7F);
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        $display("reset during conversion: checked");

        // randomized traffic with occasional reset, checked by the model
        for (int k = 0; k < 600; k++) begin
            sum_valid = ($urandom_range(0, 99) < 35);
            sum = DW'($urandom) | ((DW+1)'($urandom_range(0, 1)) << DW);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; sum_valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        $display("random traffic: 600 cycles");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // absolute time guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
